cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Common data bus (CDB) arbiter for the Tomasulo core.
- Arbitrates among functional-unit result producers: load/store queue, add/sub RS, mul/div RS and branch unit. Grants one per cycle.
- Drives a registered CDB broadcast (ROB tag + value), consumed by the ROB, reservation stations and register bank.
- Honours ROB back-pressure and a pipeline flush.

Parameters:
- NREQ, 4, number of requesters (0=load/store, 1=add, 2=mul, 3=branch)
- TAG_W, 3, ROB tag width (8-entry ROB)
- DATA_W, 16, result width
- CNT_W, 8, width of the broadcast counter

Ports:
- clk1  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  requester i has a result pending
- req_tag  input  NREQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
- req_data  input  NREQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
- req_ready  output  NREQ  one-hot grant; requester i transfers when valid&ready
- cdb_stall  input  1  ROB cannot accept this cycle; hold broadcast
- flush  input  1  mispredict flush; drop pending broadcast
- cdb_valid  output  1  broadcast valid
- cdb_tag  output  TAG_W  broadcast ROB tag
- cdb_data  output  DATA_W  broadcast value
- cdb_src  output  2  index of the requester that produced the broadcast
- bcast_cnt  output  CNT_W  number of completed broadcasts, wrapping

Behaviour:
- Reset (async, rst_n=0):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, bcast_cnt=0.
  - Round-robin pointer rr_ptr=0; req_ready=0.
- Output register is "free" when cdb_valid=0 or cdb_stall=0.
- req_ready is combinational and one-hot, at most one bit set.
  - Set only when free=1, flush=0, and the winner has req_valid=1.
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
- Transfer (req_valid[i]&req_ready[i]) at edge:
  - cdb_* loads the requester's tag and data, with cdb_src=i and cdb_valid=1.
  - rr_ptr <= (i+1) mod NREQ.
- Latency: 1 cycle, from accepted request to cdb_valid.
- Back-to-back: a new grant is allowed every cycle while cdb_stall=0.
- cdb_valid=1 and cdb_stall=1: cdb_* hold unchanged, req_ready=0, rr_ptr unchanged.
- Completed broadcast = cdb_valid=1 and cdb_stall=0 at an edge.
  - bcast_cnt increments on each, wrapping from 2^CNT_W-1 to 0.
  - If no new transfer occurs in the same cycle, cdb_valid falls to 0.
- Requesters must hold valid/tag/data stable until granted. A drop before grant is legal; the arbiter keeps no memory of it.
- flush=1:
  - At the next edge cdb_valid <= 0 (broadcast discarded, not counted); req_ready=0 that cycle; rr_ptr unchanged.
  - Flush takes priority over stall and over a new grant.
- No requests: req_ready=0, rr_ptr unchanged.
- Reset asserted mid-broadcast clears everything immediately; the in-flight result is lost.

Optional Feature:
- CDB_LDST_PRIO_EN
- Defined: requester 0 (load/store queue) wins whenever req_valid[0]=1, overriding round-robin; rr_ptr is not updated on a requester-0 grant.
  - Requesters 1..NREQ-1 keep round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters.

Test Plan:
- Reset: rst_n=0 with random inputs -> all outputs 0, req_ready=0; after release with no requests, outputs stay 0.
- Single request: req_valid=4'b0010, tag=5, data=16'h00A3 -> req_ready=4'b0010 same cycle; next cycle cdb_valid=1, tag=5, data=00A3, src=1; bcast_cnt=1 after one more edge.
- Round-robin: req_valid=4'b1111 held for 4 cycles (each requester re-presents) -> grants in order 0,1,2,3; fifth cycle grants 0 again.
- Stall: broadcast tag=2 valid, cdb_stall=1 for 3 cycles with req_valid=4'b0100 -> cdb_* held, req_ready=0 for 3 cycles, bcast_cnt unchanged; on stall release, requester 2 granted the same cycle.
- Flush: cdb_valid=1, flush=1, cdb_stall=1, req_valid=4'b0001 -> no grant; next cycle cdb_valid=0, bcast_cnt unchanged.
- CDB_LDST_PRIO_EN defined: req_valid=4'b1011 continuously, rr_ptr at 1 -> requester 0 granted every cycle. Without the macro -> grants 1,3,0,1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: requester handshakes, ROB control, broadcast outputs.
// slave = arbiter side, master = requesters/ROB side.
interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_stall;
  logic                   flush;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;
  logic [CNT_W-1:0]       bcast_cnt;

  modport slave (
    input  req_valid, req_tag, req_data,
    input  cdb_stall, flush,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_data,
    output cdb_src, bcast_cnt
  );

  modport master (
    output req_valid, req_tag, req_data,
    output cdb_stall, flush,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    input  cdb_src, bcast_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one FU result per cycle into a
// registered broadcast (tag/data/src), with ROB stall and flush.
// Ports: clk1, rst_n (async, active low), bus (cdb_arbiter_if.slave).
// Option: define CDB_LDST_PRIO_EN to give requester 0 fixed priority.
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic           clk1,
  input  logic           rst_n,
  cdb_arbiter_if.slave   bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic              found;
  int                win_i;
  int                best_d;
  int                d;
  int                nxt_ptr;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic              free;
  logic              grant;
  logic              done;

`ifdef CDB_LDST_PRIO_EN
  int                start;
`endif

  // Winner = valid requester at smallest rotated distance from rr_ptr.
  always_comb begin
    found  = 1'b0;
    win_i  = 0;
    best_d = NREQ;
    d      = 0;
`ifdef CDB_LDST_PRIO_EN
    // Requesters 1..NREQ-1 rotate among themselves; 0 overrides.
    start = (rr_ptr == '0) ? 1 : int'(rr_ptr);
    for (int i = 1; i < NREQ; i++) begin
      d = (i + NREQ - 1 - start) % (NREQ - 1);
      if (bus.req_valid[i] && d < best_d) begin
        best_d = d;
        win_i  = i;
        found  = 1'b1;
      end
    end
    if (bus.req_valid[0]) begin
      found = 1'b1;
      win_i = 0;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(rr_ptr)) % NREQ;
      if (bus.req_valid[i] && d < best_d) begin
        best_d = d;
        win_i  = i;
        found  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == win_i) begin
        win_tag  = bus.req_tag[i*TAG_W +: TAG_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign free    = !bus.cdb_valid || !bus.cdb_stall;
  assign grant   = rst_n && free && !bus.flush && found;
  assign done    = bus.cdb_valid && !bus.cdb_stall && !bus.flush;
  assign nxt_ptr = (win_i + 1) % NREQ;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && i == win_i) begin
        bus.req_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
      bus.bcast_cnt <= '0;
      rr_ptr        <= '0;
    end else begin
      if (bus.flush) begin
        bus.cdb_valid <= 1'b0;
      end else if (grant) begin
        bus.cdb_valid <= 1'b1;
        bus.cdb_tag   <= win_tag;
        bus.cdb_data  <= win_data;
        bus.cdb_src   <= win_i[1:0];
`ifdef CDB_LDST_PRIO_EN
        if (win_i != 0) begin
          rr_ptr <= nxt_ptr[PTR_W-1:0];
        end
`else
        rr_ptr <= nxt_ptr[PTR_W-1:0];
`endif
      end else if (done) begin
        bus.cdb_valid <= 1'b0;
      end
      if (done) begin
        bus.bcast_cnt <= bus.bcast_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, round-robin,
// stall, flush, 1011 pattern, counter wrap, reset mid-broadcast.
module tb_cdb_arbiter;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic clk1;
  logic rst_n;
  int   passed;
  int   total;

  cdb_arbiter_if #(
    .NREQ(NREQ), .TAG_W(TAG_W),
    .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) bus ();

  cdb_arbiter #(
    .NREQ(NREQ), .TAG_W(TAG_W),
    .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] v);
    bus.req_tag[i*TAG_W +: TAG_W]    = t;
    bus.req_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic chk_cdb(input string tag,
                         input logic vld,
                         input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] v,
                         input logic [1:0] s);
    chk({tag, "_valid"}, 32'(bus.cdb_valid), 32'(vld));
    chk({tag, "_tag"}, 32'(bus.cdb_tag), 32'(t));
    chk({tag, "_data"}, 32'(bus.cdb_data), 32'(v));
    chk({tag, "_src"}, 32'(bus.cdb_src), 32'(s));
  endtask

  logic [1:0] exp_seq [5];
  logic [1:0] pat_seq [4];

  initial begin
    passed = 0;
    total  = 0;

    // Reset with random inputs
    rst_n         = 1'b0;
    bus.req_valid = 4'($urandom);
    bus.req_tag   = 12'($urandom);
    bus.req_data  = 64'({$urandom, $urandom});
    bus.cdb_stall = 1'($urandom);
    bus.flush     = 1'($urandom);
    #3;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk_cdb("rst", 1'b0, '0, '0, '0);
    chk("rst_cnt", 32'(bus.bcast_cnt), 0);
    tick();
    bus.req_valid = '0;
    bus.cdb_stall = 1'b0;
    bus.flush     = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ready", 32'(bus.req_ready), 0);
    chk_cdb("idle", 1'b0, '0, '0, '0);
    chk("idle_cnt", 32'(bus.bcast_cnt), 0);

    // Round-robin: all four valid, rr_ptr starts at 0
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'(i + 1), 16'(16'h1000 + i));
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready),
          32'(4'b0001 << exp_seq[k]));
      tick();
      chk_cdb("rr_cdb", 1'b1, 3'(exp_seq[k] + 1),
              16'(16'h1000 + exp_seq[k]), exp_seq[k]);
    end
    chk("rr_cnt", 32'(bus.bcast_cnt), 4);

    // Single request from 1 (rr_ptr now 1)
    bus.req_valid = 4'b0010;
    set_req(1, 3'd5, 16'h00A3);
    #1;
    chk("one_ready", 32'(bus.req_ready), 32'(4'b0010));
    tick();
    bus.req_valid = 4'b0000;
    chk_cdb("one", 1'b1, 3'd5, 16'h00A3, 2'd1);
    chk("one_cnt0", 32'(bus.bcast_cnt), 5);
    #1;
    chk("none_ready", 32'(bus.req_ready), 0);
    tick();
    chk("one_fall", 32'(bus.cdb_valid), 0);
    chk("one_cnt1", 32'(bus.bcast_cnt), 6);

    // Stall: broadcast tag 2 from requester 2 (rr_ptr now 2)
    bus.req_valid = 4'b0100;
    set_req(2, 3'd2, 16'h2222);
    tick();
    chk_cdb("st_pre", 1'b1, 3'd2, 16'h2222, 2'd2);
    bus.cdb_stall = 1'b1;
    set_req(2, 3'd6, 16'h6666);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_ready", 32'(bus.req_ready), 0);
      tick();
      chk_cdb("st_hold", 1'b1, 3'd2, 16'h2222, 2'd2);
      chk("st_cnt", 32'(bus.bcast_cnt), 6);
    end
    bus.cdb_stall = 1'b0;
    #1;
    chk("st_rel_ready", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    chk_cdb("st_rel", 1'b1, 3'd6, 16'h6666, 2'd2);
    chk("st_rel_cnt", 32'(bus.bcast_cnt), 7);

    // Flush beats stall and a pending request (rr_ptr now 3)
    bus.flush     = 1'b1;
    bus.cdb_stall = 1'b1;
    bus.req_valid = 4'b0001;
    set_req(0, 3'd7, 16'h7777);
    #1;
    chk("fl_ready", 32'(bus.req_ready), 0);
    tick();
    chk("fl_valid", 32'(bus.cdb_valid), 0);
    chk("fl_cnt", 32'(bus.bcast_cnt), 7);
    bus.flush     = 1'b0;
    bus.cdb_stall = 1'b0;
    #1;
    chk("fl_post_ready", 32'(bus.req_ready), 32'(4'b0001));
    tick();
    chk_cdb("fl_post", 1'b1, 3'd7, 16'h7777, 2'd0);
    chk("fl_post_cnt", 32'(bus.bcast_cnt), 7);

    // 1011 pattern with rr_ptr at 1
`ifdef CDB_LDST_PRIO_EN
    pat_seq = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    pat_seq = '{2'd1, 2'd3, 2'd0, 2'd1};
`endif
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'(i), 16'(16'hB000 + i));
    bus.req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pat_ready", 32'(bus.req_ready),
          32'(4'b0001 << pat_seq[k]));
      tick();
      chk_cdb("pat_cdb", 1'b1, 3'(pat_seq[k]),
              16'(16'hB000 + pat_seq[k]), pat_seq[k]);
    end
    chk("pat_cnt", 32'(bus.bcast_cnt), 11);

    // Counter wrap: requester 3 alone, one broadcast per edge
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 244; k++) tick();
    chk("wrap_max", 32'(bus.bcast_cnt), 255);
    tick();
    chk("wrap_zero", 32'(bus.bcast_cnt), 0);
    chk("wrap_valid", 32'(bus.cdb_valid), 1);

    // Reset mid-broadcast clears immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk_cdb("mrst", 1'b0, '0, '0, '0);
    chk("mrst_ready", 32'(bus.req_ready), 0);
    tick();
    chk("mrst_cnt", 32'(bus.bcast_cnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
